// File: rtl/row_scan_sequencer_if.sv
// Handshake bundle between row_scan_sequencer, frame control, the dual-row shifter and the filter stage.
// Optional abort pair is present only when ROW_SCAN_ABORT_EN is defined.
interface row_scan_sequencer_if #(
    parameter int ROW_W = 9
);
    logic             i_start;
    logic             o_busy;
    logic             o_frame_done;
    logic             o_drs_trig;
    logic             o_drs_init_en;
    logic [ROW_W-1:0] o_drs_row_init;
    logic [ROW_W-1:0] o_drs_row_read;
    logic             i_drs_done;
    logic             o_proc_trig;
    logic [ROW_W-1:0] o_proc_row;
    logic             i_proc_done;
`ifdef ROW_SCAN_ABORT_EN
    logic             i_abort;
    logic             o_aborted;
`endif

    // Sequencer side
    modport master (
`ifdef ROW_SCAN_ABORT_EN
        input  i_abort,
        output o_aborted,
`endif
        input  i_start,
        output o_busy,
        output o_frame_done,
        output o_drs_trig,
        output o_drs_init_en,
        output o_drs_row_init,
        output o_drs_row_read,
        input  i_drs_done,
        output o_proc_trig,
        output o_proc_row,
        input  i_proc_done
    );

    // Frame control / shifter / filter side
    modport slave (
`ifdef ROW_SCAN_ABORT_EN
        output i_abort,
        input  o_aborted,
`endif
        output i_start,
        input  o_busy,
        input  o_frame_done,
        input  o_drs_trig,
        input  o_drs_init_en,
        input  o_drs_row_init,
        input  o_drs_row_read,
        output i_drs_done,
        input  o_proc_trig,
        input  o_proc_row,
        output i_proc_done
    );
endinterface

// File: rtl/row_scan_sequencer.sv
// Frame-level row walker: init read of rows 0/1, one shift read per later row, filter handshake per row pair.
// Define ROW_SCAN_ABORT_EN to add the i_abort / o_aborted frame abort.
module row_scan_sequencer #(
    parameter int ROW_W   = 9,
    parameter int ROW_MAX = 511
) (
    input logic                  i_clk,
    input logic                  i_rst,
    row_scan_sequencer_if.master scan
);
    typedef enum logic [3:0] {
        IDLE,
        INIT_RD,
        INIT_REL,
        PROC,
        PROC_REL,
        NEXT,
        RD,
        RD_REL,
        FDONE
    } state_t;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_MAX);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             drs_trig;
    logic             drs_trig_nxt;
    logic             init_en;
    logic             init_en_nxt;
    logic [ROW_W-1:0] row_read;
    logic [ROW_W-1:0] row_read_nxt;
    logic             proc_trig;
    logic             proc_trig_nxt;
    logic [ROW_W-1:0] proc_row;
    logic [ROW_W-1:0] proc_row_nxt;
    logic             done_reg;
    logic             done_nxt;
    logic             abort_req;

`ifdef ROW_SCAN_ABORT_EN
    logic abort_flag;
    logic abort_flag_nxt;
    logic aborted;
    logic aborted_nxt;

    // A pulse seen in the release state itself counts as well as the sticky flag.
    assign abort_req = abort_flag | scan.i_abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            drs_trig  <= 1'b0;
            init_en   <= 1'b0;
            row_read  <= '0;
            proc_trig <= 1'b0;
            proc_row  <= '0;
            done_reg  <= 1'b0;
`ifdef ROW_SCAN_ABORT_EN
            abort_flag <= 1'b0;
            aborted    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            drs_trig  <= drs_trig_nxt;
            init_en   <= init_en_nxt;
            row_read  <= row_read_nxt;
            proc_trig <= proc_trig_nxt;
            proc_row  <= proc_row_nxt;
            done_reg  <= done_nxt;
`ifdef ROW_SCAN_ABORT_EN
            abort_flag <= abort_flag_nxt;
            aborted    <= aborted_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (scan.i_start) state_nxt = INIT_RD;
            INIT_RD:  if (scan.i_drs_done) state_nxt = INIT_REL;
            INIT_REL: if (!scan.i_drs_done) state_nxt = abort_req ? IDLE : PROC;
            PROC:     if (scan.i_proc_done) state_nxt = PROC_REL;
            PROC_REL: if (!scan.i_proc_done) state_nxt = abort_req ? IDLE : NEXT;
            NEXT: begin
                if (abort_req)
                    state_nxt = IDLE;
                else if (row_read == ROW_LAST)
                    state_nxt = FDONE;
                else
                    state_nxt = RD;
            end
            RD:       if (scan.i_drs_done) state_nxt = RD_REL;
            RD_REL:   if (!scan.i_drs_done) state_nxt = abort_req ? IDLE : PROC;
            FDONE:    if (!scan.i_start) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are registered: each value below becomes visible on the edge that takes the transition.
    always_comb begin
        drs_trig_nxt  = drs_trig;
        init_en_nxt   = init_en;
        row_read_nxt  = row_read;
        proc_trig_nxt = proc_trig;
        proc_row_nxt  = proc_row;
        done_nxt      = done_reg;
        case (state)
            IDLE: begin
                if (state_nxt == INIT_RD) begin
                    drs_trig_nxt = 1'b1;
                    init_en_nxt  = 1'b1;
                    row_read_nxt = ROW_ONE;
                end
            end
            INIT_RD, RD: begin
                if (state_nxt != state) begin
                    drs_trig_nxt = 1'b0;
                    init_en_nxt  = 1'b0;
                end
            end
            INIT_REL, RD_REL: begin
                if (state_nxt == PROC) begin
                    proc_trig_nxt = 1'b1;
                    proc_row_nxt  = row_read - ROW_ONE;
                end
            end
            PROC: begin
                if (state_nxt == PROC_REL) proc_trig_nxt = 1'b0;
            end
            NEXT: begin
                if (state_nxt == FDONE) begin
                    done_nxt = 1'b1;
                end else if (state_nxt == RD) begin
                    row_read_nxt = row_read + ROW_ONE;
                    drs_trig_nxt = 1'b1;
                    init_en_nxt  = 1'b0;
                end
            end
            FDONE: begin
                if (state_nxt == IDLE) done_nxt = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef ROW_SCAN_ABORT_EN
    // Only an abort can bring a busy state other than FDONE back to IDLE.
    always_comb begin
        aborted_nxt    = (state != IDLE) && (state != FDONE) && (state_nxt == IDLE);
        abort_flag_nxt = abort_flag;
        if (aborted_nxt)
            abort_flag_nxt = 1'b0;
        else if (scan.i_abort && (state != IDLE) && (state != FDONE))
            abort_flag_nxt = 1'b1;
    end

    assign scan.o_aborted = aborted;
`endif

    assign scan.o_busy         = (state != IDLE);
    assign scan.o_frame_done   = done_reg & scan.i_start;
    assign scan.o_drs_trig     = drs_trig;
    assign scan.o_drs_init_en  = init_en;
    assign scan.o_drs_row_init = '0;
    assign scan.o_drs_row_read = row_read;
    assign scan.o_proc_trig    = proc_trig;
    assign scan.o_proc_row     = proc_row;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Bench for row_scan_sequencer: randomized-latency shifter/filter responders, event log against a frame model.
`timescale 1ns/1ps
module tb_row_scan_sequencer;
    localparam int RW     = 2;
    localparam int RMAX   = 3;
    localparam int RW_B   = 4;
    localparam int RMAX_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    row_scan_sequencer_if #(.ROW_W(RW))   scan();
    row_scan_sequencer_if #(.ROW_W(RW_B)) scan_b();

    row_scan_sequencer #(.ROW_W(RW), .ROW_MAX(RMAX)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .scan (scan.master)
    );

    row_scan_sequencer #(.ROW_W(RW_B), .ROW_MAX(RMAX_B)) dut_b (
        .i_clk(clk),
        .i_rst(rst),
        .scan (scan_b.master)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    int sh_lat_max = 3;
    int sh_rel_fix = -1;
    int pr_lat_max = 3;
    int pr_rel_fix = -1;

    int evlog[$];
    int exp_q[$];
    bit fd_seen;
    int aborted_cnt;
    int b_drs_rises, b_proc_rises, b_init, b_read, b_prow;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ev_shift(input bit init, input int row);
        return 1000 + (init ? 500 : 0) + row;
    endfunction

    function automatic int ev_proc(input int row);
        return 2000 + row;
    endfunction

    // Frame model: read rows 1..rmax (first one is the init read), each followed by a filter pass on the upper row.
    function automatic void model_frame(input int rmax, input int stop_read);
        exp_q.delete();
        for (int r = 1; r <= rmax; r++) begin
            exp_q.push_back(ev_shift(r == 1, r));
            if (r == stop_read) break;
            exp_q.push_back(ev_proc(r - 1));
        end
    endfunction

    task automatic compare_log(input string tag);
        check_val({tag, "_len"}, evlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < evlog.size(); i++)
            check_val(tag, evlog[i], exp_q[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shifter responder: done after a random latency, released a random (or fixed) time after trig falls.
    int sh_cnt = -1;
    initial begin
        scan.i_drs_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!scan.i_drs_done) begin
                if (!scan.o_drs_trig) begin
                    sh_cnt = -1;
                end else begin
                    if (sh_cnt < 0) sh_cnt = int'($urandom_range(sh_lat_max, 0));
                    if (sh_cnt == 0) begin
                        scan.i_drs_done = 1'b1;
                        sh_cnt = -1;
                    end else sh_cnt--;
                end
            end else if (!scan.o_drs_trig) begin
                if (sh_cnt < 0) sh_cnt = (sh_rel_fix >= 0) ? sh_rel_fix : int'($urandom_range(4, 0));
                if (sh_cnt == 0) begin
                    scan.i_drs_done = 1'b0;
                    sh_cnt = -1;
                end else sh_cnt--;
            end
        end
    end

    int pr_cnt = -1;
    initial begin
        scan.i_proc_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!scan.i_proc_done) begin
                if (!scan.o_proc_trig) begin
                    pr_cnt = -1;
                end else begin
                    if (pr_cnt < 0) pr_cnt = int'($urandom_range(pr_lat_max, 0));
                    if (pr_cnt == 0) begin
                        scan.i_proc_done = 1'b1;
                        pr_cnt = -1;
                    end else pr_cnt--;
                end
            end else if (!scan.o_proc_trig) begin
                if (pr_cnt < 0) pr_cnt = (pr_rel_fix >= 0) ? pr_rel_fix : int'($urandom_range(4, 0));
                if (pr_cnt == 0) begin
                    scan.i_proc_done = 1'b0;
                    pr_cnt = -1;
                end else pr_cnt--;
            end
        end
    end

    initial begin
        scan_b.i_drs_done  = 1'b0;
        scan_b.i_proc_done = 1'b0;
        forever begin
            @(negedge clk);
            scan_b.i_drs_done  = scan_b.o_drs_trig;
            scan_b.i_proc_done = scan_b.o_proc_trig;
        end
    end

    // Monitor: logs every trig rise and checks handshake rules cycle by cycle.
    logic          prev_drs, prev_proc, prev_drs_b, prev_proc_b;
    logic          hold_init;
    logic [RW-1:0] hold_read, hold_prow;
    initial begin
        prev_drs = 0; prev_proc = 0; prev_drs_b = 0; prev_proc_b = 0;
        hold_init = 0; hold_read = '0; hold_prow = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                prev_drs = 0; prev_proc = 0; prev_drs_b = 0; prev_proc_b = 0;
            end else begin
                if (scan.o_drs_trig && !prev_drs) begin
                    evlog.push_back(ev_shift(scan.o_drs_init_en, int'(scan.o_drs_row_read)));
                    check_val("drs_rise_drs_done_low", scan.i_drs_done, 0);
                    check_val("drs_rise_proc_done_low", scan.i_proc_done, 0);
                    check_val("drs_row_init", scan.o_drs_row_init, 0);
                end else if (scan.o_drs_trig) begin
                    check_val("drs_read_stable", scan.o_drs_row_read, hold_read);
                    check_val("drs_init_stable", scan.o_drs_init_en, hold_init);
                end
                if (scan.o_proc_trig && !prev_proc) begin
                    evlog.push_back(ev_proc(int'(scan.o_proc_row)));
                    check_val("proc_rise_proc_done_low", scan.i_proc_done, 0);
                    check_val("proc_rise_drs_done_low", scan.i_drs_done, 0);
                end else if (scan.o_proc_trig) begin
                    check_val("proc_row_stable", scan.o_proc_row, hold_prow);
                end
                hold_read = scan.o_drs_row_read;
                hold_init = scan.o_drs_init_en;
                hold_prow = scan.o_proc_row;
                prev_drs  = scan.o_drs_trig;
                prev_proc = scan.o_proc_trig;
                if (scan.o_frame_done) fd_seen = 1'b1;
`ifdef ROW_SCAN_ABORT_EN
                if (scan.o_aborted) begin
                    aborted_cnt++;
                    check_val("aborted_in_idle", scan.o_busy, 0);
                end
`endif
                if (scan_b.o_drs_trig && !prev_drs_b) begin
                    b_drs_rises++;
                    b_init = int'(scan_b.o_drs_init_en);
                    b_read = int'(scan_b.o_drs_row_read);
                end
                if (scan_b.o_proc_trig && !prev_proc_b) begin
                    b_proc_rises++;
                    b_prow = int'(scan_b.o_proc_row);
                end
                prev_drs_b  = scan_b.o_drs_trig;
                prev_proc_b = scan_b.o_proc_trig;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, scan.o_busy, 0);
        check_val({tag, "_frame_done"}, scan.o_frame_done, 0);
        check_val({tag, "_drs_trig"}, scan.o_drs_trig, 0);
        check_val({tag, "_init_en"}, scan.o_drs_init_en, 0);
        check_val({tag, "_row_read"}, scan.o_drs_row_read, 0);
        check_val({tag, "_proc_trig"}, scan.o_proc_trig, 0);
        check_val({tag, "_proc_row"}, scan.o_proc_row, 0);
    endtask

    // Waits for the current frame to finish with i_start held, checks it, then releases i_start.
    task automatic finish_frame(input string tag);
        for (int n = 0; n < 600 && !scan.o_frame_done; n++) step();
        check_val({tag, "_frame_done"}, scan.o_frame_done, 1);
        check_val({tag, "_busy_at_done"}, scan.o_busy, 1);
        check_val({tag, "_trig_idle"}, {scan.o_drs_trig, scan.o_proc_trig}, 0);
        model_frame(RMAX, 0);
        compare_log(tag);
        scan.i_start = 1'b0;
        #1;
        check_val({tag, "_done_drops_with_start"}, scan.o_frame_done, 0);
        step();
        check_val({tag, "_busy_after"}, scan.o_busy, 0);
    endtask

    task automatic begin_frame();
        evlog.delete();
        fd_seen = 1'b0;
        scan.i_start = 1'b1;
    endtask

    task automatic wait_rd2(input string tag);
        for (int n = 0; n < 600 && !(scan.o_drs_trig && !scan.o_drs_init_en && scan.o_drs_row_read == 2); n++)
            step();
        check_val({tag, "_reach_rd2"}, scan.o_drs_trig && scan.o_drs_row_read == 2, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        scan.i_start   = 1'b0;
        scan_b.i_start = 1'b0;
`ifdef ROW_SCAN_ABORT_EN
        scan.i_abort   = 1'b0;
        scan_b.i_abort = 1'b0;
`endif
        aborted_cnt = 0;
        b_drs_rises = 0; b_proc_rises = 0; b_init = 0; b_read = 0; b_prow = 0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Single-pair frame
        scan_b.i_start = 1'b1;
        for (int n = 0; n < 60 && !scan_b.o_frame_done; n++) step();
        check_val("b_frame_done", scan_b.o_frame_done, 1);
        check_val("b_drs_rises", b_drs_rises, 1);
        check_val("b_init_en", b_init, 1);
        check_val("b_row_read", b_read, 1);
        check_val("b_proc_rises", b_proc_rises, 1);
        check_val("b_proc_row", b_prow, 0);
        scan_b.i_start = 1'b0;
        #1;
        check_val("b_done_drops", scan_b.o_frame_done, 0);
        step();
        check_val("b_busy_after", scan_b.o_busy, 0);

        // First trig one cycle after i_start is sampled
        begin_frame();
        step();
        check_val("first_trig", scan.o_drs_trig, 1);
        check_val("first_init_en", scan.o_drs_init_en, 1);
        check_val("first_row_read", scan.o_drs_row_read, 1);
        check_val("first_busy", scan.o_busy, 1);
        finish_frame("frame0");

        for (int f = 0; f < 4; f++) begin
            step();
            begin_frame();
            finish_frame("frame_rand");
        end

        // Long release hold on both downstream blocks
        sh_rel_fix = 5;
        pr_rel_fix = 5;
        begin_frame();
        finish_frame("frame_long_rel");
        sh_rel_fix = -1;
        pr_rel_fix = -1;

        // i_start dropped mid-frame
        begin_frame();
        for (int n = 0; n < 600 && !(scan.o_proc_trig && scan.o_proc_row == 1); n++) step();
        check_val("drop_reach_proc1", scan.o_proc_trig, 1);
        scan.i_start = 1'b0;
        for (int n = 0; n < 600 && scan.o_busy; n++) step();
        check_val("drop_busy_low", scan.o_busy, 0);
        check_val("drop_no_frame_done", fd_seen, 0);
        model_frame(RMAX, 0);
        compare_log("drop_log");

        // Asynchronous reset while trig is up in RD
        step();
        begin_frame();
        wait_rd2("rst");
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        scan.i_start = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int n = 0; n < 50 && (scan.i_drs_done || scan.i_proc_done); n++) step();
        check_val("rst_dones_released", {scan.i_drs_done, scan.i_proc_done}, 0);
        begin_frame();
        step();
        check_val("restart_init_en", scan.o_drs_init_en, 1);
        check_val("restart_row_read", scan.o_drs_row_read, 1);
        finish_frame("frame_after_rst");

`ifdef ROW_SCAN_ABORT_EN
        // Abort pulse during RD of row 2
        step();
        aborted_cnt = 0;
        begin_frame();
        wait_rd2("abort");
        scan.i_abort = 1'b1;
        step();
        scan.i_abort = 1'b0;
        scan.i_start = 1'b0;
        for (int n = 0; n < 600 && scan.o_busy; n++) step();
        step();
        step();
        check_val("abort_busy_low", scan.o_busy, 0);
        check_val("abort_pulse_cycles", aborted_cnt, 1);
        check_val("abort_no_frame_done", fd_seen, 0);
        model_frame(RMAX, 2);
        compare_log("abort_log");
        begin_frame();
        finish_frame("frame_after_abort");
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
